// File: rtl/elevator_controller.sv
// Four-floor elevator sequencer: latches calls, serves them in SCAN order,
// and times floor-to-floor travel and door dwell with one shared counter.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | car parked, door closed, choosing the next move
// MOVING    | car travelling one floor per TRAVEL_CYCLES
// DOOR_OPEN | car stopped, door open for DOOR_CYCLES
module elevator_controller #(
  parameter int TRAVEL_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES   = 200_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] callReq,
  output logic [1:0] floorSel,
  output logic       door,
  output logic       moving,
  output logic       dirUp,
  output logic [3:0] pending
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] TRAVEL_TC = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_TC   = CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    floor_nx, step_floor;
  logic          dir_nx;
  logic [3:0]    clr, req_mask;
  logic [3:0]    above, below, ahead, behind, step_ahead;

  function automatic logic [3:0] mask_above(input logic [1:0] f);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [3:0] mask_below(input logic [1:0] f);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  always_comb begin
    state_nx   = state;
    floor_nx   = floorSel;
    dir_nx     = dirUp;
    clr        = '0;
    req_mask   = '0;
    cnt_nx     = cnt + CW'(1);
    above      = pending & mask_above(floorSel);
    below      = pending & mask_below(floorSel);
    ahead      = dirUp ? above : below;
    behind     = dirUp ? below : above;
    step_floor = dirUp ? floorSel + 2'd1 : floorSel - 2'd1;
    // "ahead" as seen from the floor the car is about to reach
    step_ahead = pending & (dirUp ? mask_above(step_floor) : mask_below(step_floor));

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pending[floorSel]) begin
          state_nx      = DOOR_OPEN;
          clr[floorSel] = 1'b1;
        end else if (|ahead) begin
          state_nx = MOVING;
        end else if (|behind) begin
          dir_nx   = ~dirUp;
          state_nx = MOVING;
        end
      end
      MOVING: begin
        if (cnt == TRAVEL_TC) begin
          cnt_nx   = '0;
          floor_nx = step_floor;
          if (pending[step_floor]) begin
            state_nx        = DOOR_OPEN;
            clr[step_floor] = 1'b1;
          end else if (!(|step_ahead)) begin
            state_nx = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        req_mask[floorSel] = 1'b1;
        if (cnt == DOOR_TC) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      floorSel <= 2'd0;
      dirUp    <= 1'b1;
      pending  <= 4'b0000;
      door     <= 1'b0;
      moving   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      floorSel <= floor_nx;
      dirUp    <= dir_nx;
      pending  <= (pending | (callReq & ~req_mask)) & ~clr;
      door     <= (state_nx == DOOR_OPEN);
      moving   <= (state_nx == MOVING);
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: expected stops (floor, direction) are queued
// when calls are issued and checked when the door opens; timing checked inline.
module tb_elevator_controller;

  localparam int TRAVEL_C = 4;
  localparam int DOOR_C   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] callReq;
  logic [1:0] floorSel;
  logic       door;
  logic       moving;
  logic       dirUp;
  logic [3:0] pending;

  typedef struct packed {
    logic [1:0] floor;
    logic       dir;
  } stop_t;

  stop_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  door_q  = 1'b0;
  int    door_len = 0;

  elevator_controller #(.TRAVEL_CYCLES(TRAVEL_C), .DOOR_CYCLES(DOOR_C)) dut (
    .clk(clk), .rst_n(rst_n), .callReq(callReq), .floorSel(floorSel),
    .door(door), .moving(moving), .dirUp(dirUp), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stop(input int f, input int d);
    stop_t e;
    e.floor = 2'(f);
    e.dir   = 1'(d);
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(moving == 1'b0 && door == 1'b0 && pending == 4'b0) && n < budget) begin
      tick();
      n++;
    end
    check_val("idle_reached", int'(n < budget), 1);
  endtask

  task automatic wait_door(input int budget);
    int n = 0;
    while (!door && n < budget) begin
      tick();
      n++;
    end
    check_val("door_reached", door, 1);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_floor"}, floorSel, 0);
    check_val({tag, "_door"}, door, 0);
    check_val({tag, "_moving"}, moving, 0);
    check_val({tag, "_dir"}, dirUp, 1);
    check_val({tag, "_pending"}, pending, 0);
  endtask

  // Stop monitor: pops the scoreboard on each door opening, checks dwell length
  always @(negedge clk) begin
    stop_t e;
    if (door && !door_q) begin
      if (sb.size() == 0) begin
        check_val("stop_unexpected", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_val("stop_floor", floorSel, e.floor);
        check_val("stop_dir", dirUp, e.dir);
      end
      door_len = 1;
    end else if (door) begin
      door_len++;
    end else if (door_q) begin
      check_val("door_len", door_len, DOOR_C);
    end
    door_q = door;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    callReq = 4'b0;
    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // 1: single call to floor 2 from floor 0
    push_stop(2, 1);
    callReq = 4'b0100;
    tick();
    callReq = 4'b0;
    check_val("s1_latch", pending, 4'b0100);
    check_val("s1_wait", moving, 0);
    tick();
    check_val("s1_depart", moving, 1);
    check_val("s1_f0", floorSel, 0);
    repeat (3) tick();
    check_val("s1_still0", floorSel, 0);
    tick();
    check_val("s1_f1", floorSel, 1);
    check_val("s1_mov1", moving, 1);
    repeat (4) tick();
    check_val("s1_f2", floorSel, 2);
    check_val("s1_door", door, 1);
    check_val("s1_stop", moving, 0);
    check_val("s1_clr", pending, 0);
    repeat (2) tick();
    check_val("s1_door_hold", door, 1);
    tick();
    check_val("s1_door_close", door, 0);
    check_val("s1_idle", moving, 0);

    // 2: local call at floor 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_val("s2_floor", floorSel, 0);
    push_stop(0, 1);
    callReq = 4'b0001;
    tick();
    callReq = 4'b0;
    tick();
    check_val("s2_door", door, 1);
    check_val("s2_pending", pending, 0);
    repeat (3) begin
      check_val("s2_moving", moving, 0);
      tick();
    end
    check_val("s2_door_close", door, 0);

    // 3: calls 1 and 0 arrive during the first leg toward 3
    push_stop(1, 1);
    push_stop(3, 1);
    push_stop(0, 0);
    callReq = 4'b1000;
    tick();
    callReq = 4'b0;
    tick();
    check_val("s3_depart", moving, 1);
    callReq = 4'b0011;
    tick();
    callReq = 4'b0;
    check_val("s3_latch", pending, 4'b1011);
    wait_idle(200);
    check_val("s3_floor", floorSel, 0);
    check_val("s3_dir", dirUp, 0);

    // 4: held call for the open-door floor is masked
    push_stop(2, 1);
    callReq = 4'b0100;
    tick();
    callReq = 4'b0;
    wait_door(50);
    callReq = 4'b0100;
    tick();
    check_val("s4_door1", door, 1);
    check_val("s4_mask1", pending, 0);
    tick();
    check_val("s4_door2", door, 1);
    check_val("s4_mask2", pending, 0);
    callReq = 4'b0;
    tick();
    check_val("s4_close", door, 0);
    check_val("s4_mask3", pending, 0);
    tick();
    check_val("s4_no_reopen", door, 0);
    check_val("s4_idle", moving, 0);

    // 5: simultaneous calls 3 and 1 from floor 2
    push_stop(3, 1);
    push_stop(1, 0);
    callReq = 4'b1010;
    tick();
    callReq = 4'b0;
    check_val("s5_latch", pending, 4'b1010);
    wait_idle(200);
    check_val("s5_floor", floorSel, 1);
    check_val("s5_dir", dirUp, 0);

    // 6: reset while leaving floor 1
    callReq = 4'b1000;
    tick();
    callReq = 4'b0;
    tick();
    check_val("s6_depart", moving, 1);
    check_val("s6_turn", dirUp, 1);
    repeat (2) tick();
    check_val("s6_mid_floor", floorSel, 1);
    check_val("s6_mid_pending", pending, 4'b1000);
    rst_n = 1'b0;
    tick();
    check_reset("s6_rst");
    rst_n = 1'b1;
    repeat (2) tick();
    check_val("s6_after_moving", moving, 0);
    check_val("s6_after_pending", pending, 0);

    check_val("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
